// File: rtl/alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arbiter : round-robin sequencer sharing one alu between NREQ requesters.
// Optional EXEC watchdog enabled by macro ALU_ARB_TIMEOUT_EN.     Rev 1.0
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ           = 4,
  parameter int N              = 32,
  parameter int WIDTH_OPCODE   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*WIDTH_OPCODE-1:0] req_opcode,
  input  logic [NREQ*N-1:0]            req_dataA,
  input  logic [NREQ*N-1:0]            req_dataB,
  input  logic [NREQ*N-1:0]            req_imm,
  output logic [NREQ-1:0]              req_ack,
  output logic [NREQ-1:0]              resp_valid,
  output logic [N-1:0]                 resp_data,
  output logic                         resp_zero,
  output logic                         resp_err,
  output logic                         busy,
  output logic                         alu_en,
  output logic [WIDTH_OPCODE-1:0]      alu_opcode,
  output logic [N-1:0]                 alu_dataA,
  output logic [N-1:0]                 alu_dataB,
  output logic [N-1:0]                 alu_imm,
  input  logic                         alu_valid,
  input  logic                         alu_zero,
  input  logic [N-1:0]                 alu_data
);

  localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gnt;
  logic [IDXW-1:0] pick;
  logic            found;
  logic            op_err;

  logic [WIDTH_OPCODE-1:0] op_arr  [NREQ];
  logic [N-1:0]            a_arr   [NREQ];
  logic [N-1:0]            b_arr   [NREQ];
  logic [N-1:0]            imm_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i]  = req_opcode[i*WIDTH_OPCODE +: WIDTH_OPCODE];
    assign a_arr[i]   = req_dataA[i*N +: N];
    assign b_arr[i]   = req_dataB[i*N +: N];
    assign imm_arr[i] = req_imm[i*N +: N];
  end

  function automatic logic op_supported(input logic [WIDTH_OPCODE-1:0] op);
    return (op <= WIDTH_OPCODE'(6)) || (op == WIDTH_OPCODE'(9)) ||
           (op == WIDTH_OPCODE'(11)) || (op == WIDTH_OPCODE'(14)) ||
           (op == WIDTH_OPCODE'(15));
  endfunction

  // First set request at or above ptr, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IDXW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0] to_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      op_err     <= 1'b0;
      req_ack    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_err   <= 1'b0;
      alu_en     <= 1'b0;
      alu_opcode <= '0;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      alu_imm    <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      req_ack    <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt        <= pick;
            alu_opcode <= op_arr[pick];
            alu_dataA  <= a_arr[pick];
            alu_dataB  <= b_arr[pick];
            alu_imm    <= imm_arr[pick];
            op_err     <= !op_supported(op_arr[pick]);
            alu_en     <= op_supported(op_arr[pick]);
            req_ack    <= ONE_HOT0 << pick;
            state      <= EXEC;
`ifdef ALU_ARB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        EXEC: begin
          // Unsupported ops spend this cycle with alu_en low, then report err.
          if (op_err) begin
            resp_valid <= ONE_HOT0 << gnt;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else if (alu_valid) begin
            alu_en     <= 1'b0;
            resp_valid <= ONE_HOT0 << gnt;
            resp_data  <= alu_data;
            resp_zero  <= alu_zero;
            resp_err   <= 1'b0;
            state      <= RESP;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (to_cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
            alu_en     <= 1'b0;
            resp_valid <= ONE_HOT0 << gnt;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else begin
            to_cnt     <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          ptr       <= (gnt == IDXW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          resp_data <= '0;
          resp_zero <= 1'b0;
          resp_err  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter : directed stimulus, alu stub, transaction-level model checked every cycle.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int W    = 4;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_opcode = '0;
  logic [NREQ*N-1:0] req_dataA = '0;
  logic [NREQ*N-1:0] req_dataB = '0;
  logic [NREQ*N-1:0] req_imm = '0;
  logic [NREQ-1:0]   req_ack, resp_valid;
  logic [N-1:0]      resp_data;
  logic              resp_zero, resp_err, busy, alu_en;
  logic [W-1:0]      alu_opcode;
  logic [N-1:0]      alu_dataA, alu_dataB, alu_imm, alu_data;
  logic              alu_valid, alu_zero;

  alu_arbiter #(.NREQ(NREQ), .N(N), .WIDTH_OPCODE(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode),
    .req_dataA(req_dataA), .req_dataB(req_dataB), .req_imm(req_imm),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_dataA(alu_dataA),
    .alu_dataB(alu_dataB), .alu_imm(alu_imm), .alu_valid(alu_valid),
    .alu_zero(alu_zero), .alu_data(alu_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // ---------------- alu stub (Q16 multiply/divide are multi-cycle) ----------
  function automatic logic [N-1:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic [N-1:0] imm);
    logic [63:0] p;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  begin p = {32'd0, a} * {32'd0, b}; return p[47:16]; end
      4'd5:  begin
               if (b == '0) return '1;
               p = {16'd0, a, 16'd0} / {32'd0, b};
               return p[31:0];
             end
      4'd6:  return a ^ b;
      4'd9:  return a + imm;
      4'd11: return a << b[4:0];
      4'd14: return a >> b[4:0];
      4'd15: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op);
    return (op == 4'd4) ? 3 : (op == 4'd5) ? 5 : 1;
  endfunction

  bit force_low = 1'b0;
  int en_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) en_cnt <= 0;
    else     en_cnt <= alu_en ? en_cnt + 1 : 0;
  end

  always_comb begin
    alu_valid = alu_en && !force_low && (en_cnt >= lat(alu_opcode) - 1);
    alu_data  = alu_fn(alu_opcode, alu_dataA, alu_dataB, alu_imm);
    alu_zero  = (alu_data == '0);
  end

  // ---------------- transaction-level model --------------------------------
  int cyc = 0, free_cyc = 0, ack_cyc = -1, resp_cyc = -1, en_lo = 1, en_hi = 0;
  int m_ptr = 0, m_g = 0, m_sel = 0, m_e = 0;
  logic [3:0]   m_op;
  logic [N-1:0] m_a, m_b, m_imm, m_data;
  logic         m_err, m_zero, m_sup;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      free_cyc = 0; ack_cyc = -1; resp_cyc = -1; en_lo = 1; en_hi = 0; m_ptr = 0;
    end else begin
      cyc++;
      if (cyc - 1 >= free_cyc && req != '0) begin
        m_sel = -1;
        for (int k = 0; k < NREQ; k++)
          if (m_sel < 0 && req[(m_ptr + k) % NREQ]) m_sel = (m_ptr + k) % NREQ;
        m_g   = m_sel;
        m_op  = req_opcode[m_g*W +: W];
        m_a   = req_dataA[m_g*N +: N];
        m_b   = req_dataB[m_g*N +: N];
        m_imm = req_imm[m_g*N +: N];
        m_sup = m_op inside {[4'd0:4'd6], 4'd9, 4'd11, 4'd14, 4'd15};
        if (!m_sup) begin
          m_e = 1; m_err = 1'b1; m_data = '0; m_zero = 1'b0;
        end else if (force_low) begin
`ifdef ALU_ARB_TIMEOUT_EN
          m_e = TO;
`else
          m_e = 1000000;
`endif
          m_err = 1'b1; m_data = '0; m_zero = 1'b0;
        end else begin
          m_e = lat(m_op); m_err = 1'b0;
          m_data = alu_fn(m_op, m_a, m_b, m_imm); m_zero = (m_data == '0);
        end
        ack_cyc  = cyc;
        resp_cyc = cyc + m_e;
        free_cyc = cyc + m_e + 1;
        if (m_sup) begin en_lo = cyc; en_hi = cyc + m_e - 1; end
        else       begin en_lo = 1;   en_hi = 0; end
        m_ptr = (m_g + 1) % NREQ;
      end
    end
  end

  // ---------------- per-cycle compare --------------------------------------
  logic [NREQ-1:0] exp_oh;
  logic            exp_en;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      exp_oh = NREQ'(1) << m_g;
      exp_en = (cyc >= en_lo) && (cyc <= en_hi);
      chk("req_ack", 64'(req_ack), (cyc == ack_cyc) ? 64'(exp_oh) : 64'd0);
      chk("resp_valid", 64'(resp_valid), (cyc == resp_cyc) ? 64'(exp_oh) : 64'd0);
      if (cyc == resp_cyc) begin
        chk("resp_data", 64'(resp_data), 64'(m_data));
        chk("resp_zero", 64'(resp_zero), 64'(m_zero));
        chk("resp_err", 64'(resp_err), 64'(m_err));
      end
      chk("alu_en", 64'(alu_en), 64'(exp_en));
      if (exp_en) begin
        chk("alu_opcode", 64'(alu_opcode), 64'(m_op));
        chk("alu_dataA", 64'(alu_dataA), 64'(m_a));
        chk("alu_dataB", 64'(alu_dataB), 64'(m_b));
        chk("alu_imm", 64'(alu_imm), 64'(m_imm));
      end
      chk("busy", 64'(busy), 64'(cyc < free_cyc));
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic set_op(input int i, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] imm);
    req_opcode[i*W +: W] = op;
    req_dataA[i*N +: N]  = a;
    req_dataB[i*N +: N]  = b;
    req_imm[i*N +: N]    = imm;
  endtask

  task automatic wait_ack(input int i, output int c);
    c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ack[i]) begin c = cyc; break; end
    end
    if (c < 0) chk("ack_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic wait_resp(input int i, output int c, output logic [N-1:0] d,
                           output logic e, output logic z);
    c = -1; d = '0; e = 1'b0; z = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (resp_valid[i]) begin c = cyc; d = resp_data; e = resp_err; z = resp_zero; break; end
    end
    if (c < 0) chk("resp_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60) begin @(negedge clk); n++; end
    if (busy) chk("idle_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic run_op(input int i, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] imm,
                        output int al, output int rl, output logic [N-1:0] d,
                        output logic e, output logic z);
    int t, ca, cr;
    @(negedge clk);
    set_op(i, op, a, b, imm);
    req[i] = 1'b1;
    t = cyc;
    wait_ack(i, ca);
    req[i] = 1'b0;
    wait_resp(i, cr, d, e, z);
    al = ca - t;
    rl = cr - t;
  endtask

  typedef struct {
    int         i;
    logic [3:0] op;
    logic [31:0] a, b, imm;
  } vec_t;

  vec_t vecs [12];
  int   al, rl, ca, n;
  logic [N-1:0] d;
  logic e, z;
  int   rr_ord [5];
  int   rr_cyc [5];
  int   rr_exp [5];

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_alu_en", 64'(alu_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_dataA", 64'(alu_dataA), 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    #2 rst = 1'b0;

    // ---- add 5+7 on requester 0 ----
    run_op(0, 4'b0000, 32'd5, 32'd7, 32'd0, al, rl, d, e, z);
    chk("add_ack_lat", 64'(al), 64'd1);
    chk("add_resp_lat", 64'(rl), 64'd2);
    chk("add_data", 64'(d), 64'd12);
    chk("add_zero", 64'(z), 64'd0);
    chk("add_err", 64'(e), 64'd0);

    // ---- Q16 multiply 2.0*3.0 on requester 2 ----
    run_op(2, 4'b0100, 32'h0002_0000, 32'h0003_0000, 32'd0, al, rl, d, e, z);
    chk("mul_data", 64'(d), 64'h0006_0000);
    chk("mul_err", 64'(e), 64'd0);

    // ---- unsupported opcode on requester 1 ----
    run_op(1, 4'b0111, 32'd9, 32'd9, 32'd0, al, rl, d, e, z);
    chk("unsup_resp_lat", 64'(rl), 64'd2);
    chk("unsup_err", 64'(e), 64'd1);
    chk("unsup_data", 64'(d), 64'd0);

    // ---- round-robin with all four requesting ----
    @(negedge clk); #2 rst = 1'b1; #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_op(i, 4'b0001, 32'd100 + 32'(i * 3), 32'(i), 32'd0);
    req = '1;
    rr_exp = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin rr_ord[k] = -1; rr_cyc[k] = -1; end
    n = 0;
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        for (int j = 0; j < NREQ; j++) if (req_ack[j]) rr_ord[n] = j;
        rr_cyc[n] = cyc;
        n++;
      end
    end
    req = '0;
    chk("rr_count", 64'(n), 64'd5);
    for (int k = 0; k < 5; k++) chk("rr_order", 64'(rr_ord[k]), 64'(rr_exp[k]));
    chk("rr_spacing", 64'(rr_cyc[1] - rr_cyc[0]), 64'd3);
    wait_idle();

    // ---- withdrawn request while busy ----
    @(negedge clk);
    set_op(0, 4'b0100, 32'h0001_8000, 32'h0000_4000, 32'd0);
    req[0] = 1'b1;
    wait_ack(0, ca);
    req[0] = 1'b0;
    set_op(3, 4'b0000, 32'd1, 32'd1, 32'd0);
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    n = 0;
    repeat (12) begin @(negedge clk); if (req_ack[3]) n++; end
    chk("withdraw_no_ack", 64'(n), 64'd0);

    // ---- reset during divide ----
    @(negedge clk);
    set_op(1, 4'b0101, 32'h0005_0000, 32'h0002_0000, 32'd0);
    req[1] = 1'b1;
    wait_ack(1, ca);
    req[1] = 1'b0;
    @(negedge clk);
    chk("div_alu_en_before_rst", 64'(alu_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("div_rst_alu_en", 64'(alu_en), 64'd0);
    chk("div_rst_busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    n = 0;
    repeat (8) begin @(negedge clk); if (resp_valid != '0) n++; end
    chk("div_rst_no_resp", 64'(n), 64'd0);
    set_op(1, 4'b0000, 32'd2, 32'd3, 32'd0);
    set_op(3, 4'b0000, 32'd4, 32'd5, 32'd0);
    req = 4'b1010;
    n = 0;
    for (int k = 0; k < 20 && req_ack == '0; k++) @(negedge clk);
    chk("post_rst_grant", 64'(req_ack), 64'b0010);
    req[1] = 1'b0;
    wait_ack(3, ca);
    req[3] = 1'b0;
    wait_idle();

    // ---- directed opcode table ----
    vecs = '{
      '{3, 4'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0},
      '{1, 4'd3,  32'h0000_1200, 32'h0000_0034, 32'd0},
      '{2, 4'd6,  32'hAAAA_5555, 32'hFFFF_0000, 32'd0},
      '{0, 4'd9,  32'd100,       32'd0,         32'd23},
      '{3, 4'd11, 32'd1,         32'd5,         32'd0},
      '{1, 4'd14, 32'h8000_0000, 32'd31,        32'd0},
      '{2, 4'd15, 32'd3,         32'd9,         32'd0},
      '{0, 4'd8,  32'd1,         32'd2,         32'd3},
      '{3, 4'd10, 32'd1,         32'd2,         32'd3},
      '{1, 4'd12, 32'd1,         32'd2,         32'd3},
      '{2, 4'd13, 32'd1,         32'd2,         32'd3},
      '{0, 4'd1,  32'd7,         32'd7,         32'd0}
    };
    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].i, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].imm, al, rl, d, e, z);
      chk("table_resp_lat", 64'(rl), 64'd2);
    end
    chk("sub_zero_flag", 64'(z), 64'd1);
    chk("sub_zero_data", 64'(d), 64'd0);

`ifdef ALU_ARB_TIMEOUT_EN
    // ---- watchdog: alu never answers ----
    force_low = 1'b1;
    run_op(2, 4'b0000, 32'd1, 32'd2, 32'd0, al, rl, d, e, z);
    force_low = 1'b0;
    chk("to_resp_lat", 64'(rl), 64'(1 + TO));
    chk("to_err", 64'(e), 64'd1);
    chk("to_data", 64'(d), 64'd0);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

endmodule
`default_nettype wire
